// File: rtl/tow_match_ctrl.sv
// tow_match_ctrl: match controller for a two-player tug-of-war game.
//   Synchronizes and edge-detects the two player buttons, forwards one press
//   pulse per button press to the playfield while a round is in play, keeps
//   the round score and sequences rounds until one player reaches WIN_ROUNDS.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   keyL, keyR    raw asynchronous player buttons, active-high
//   start         request to begin a match (honoured in IDLE and MATCH_END)
//   pf_winL/R     playfield round-win flags
//   pressL/R      single-cycle press pulses to the playfield
//   pf_reset      synchronous reset to the playfield (IDLE and CLEAR)
//   scoreL/R      round wins per player, saturating at WIN_ROUNDS
//   match_over    high while the match has been decided
//   match_winner  00 none, 01 left, 10 right
//
// Optional feature: define TOW_LOCKOUT_EN to drop further presses from a
// player for LOCKOUT_CYCLES cycles after one of that player's presses.
module tow_match_ctrl #(
  parameter int WIN_ROUNDS     = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyL,
  input  logic       keyR,
  input  logic       start,
  input  logic       pf_winL,
  input  logic       pf_winR,
  output logic       pressL,
  output logic       pressR,
  output logic       pf_reset,
  output logic [2:0] scoreL,
  output logic [2:0] scoreR,
  output logic       match_over,
  output logic [1:0] match_winner
);

  if (WIN_ROUNDS < 1 || WIN_ROUNDS > 7) begin : g_bad_win_rounds
    $error("WIN_ROUNDS must be within 1..7");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold_cycles
    $error("HOLD_CYCLES must be within 1..255");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 15) begin : g_bad_lockout_cycles
    $error("LOCKOUT_CYCLES must be within 1..15");
  end

  localparam logic [2:0] WIN_SCORE = 3'(WIN_ROUNDS);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_ROUND_END = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  // [0] metastability flop, [1] synchronized key, [2] previous synchronized key
  logic [2:0] sync_l_r;
  logic [2:0] sync_r_r;
  logic       live_r;
  logic       arm_l_r;
  logic       arm_r_r;
  logic       cand_l_s;
  logic       cand_r_s;
  logic       fwd_l_s;
  logic       fwd_r_s;
  logic       accept_l_s;
  logic       accept_r_s;
  logic [7:0] hold_cnt_r;
  logic       score_hit_s;

  // Two-flop synchronizers plus the history flop used for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_l_r <= 3'b000;
      sync_r_r <= 3'b000;
    end else begin
      sync_l_r <= {sync_l_r[1:0], keyL};
      sync_r_r <= {sync_r_r[1:0], keyR};
    end
  end

  // A key only becomes eligible once it has really been sampled low after
  // reset; live_r marks that sync[0] holds a genuine sample rather than the
  // reset value, so a button held through reset release never fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_r  <= 1'b0;
      arm_l_r <= 1'b0;
      arm_r_r <= 1'b0;
    end else begin
      live_r  <= 1'b1;
      arm_l_r <= arm_l_r | (live_r & ~sync_l_r[0]);
      arm_r_r <= arm_r_r | (live_r & ~sync_r_r[0]);
    end
  end

  assign cand_l_s = sync_l_r[1] & ~sync_l_r[2] & arm_l_r;
  assign cand_r_s = sync_r_r[1] & ~sync_r_r[2] & arm_r_r;
  // Simultaneous presses cancel each other; nothing passes outside PLAY.
  assign fwd_l_s  = cand_l_s & ~cand_r_s & (state_r == ST_PLAY);
  assign fwd_r_s  = cand_r_s & ~cand_l_s & (state_r == ST_PLAY);

`ifdef TOW_LOCKOUT_EN
  logic [3:0] lock_l_r;
  logic [3:0] lock_r_r;

  assign accept_l_s = fwd_l_s & (lock_l_r == 4'd0);
  assign accept_r_s = fwd_r_s & (lock_r_r == 4'd0);

  // Per-player lockout counters, loaded on an accepted press and cleared when a round is set up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_l_r <= 4'd0;
      lock_r_r <= 4'd0;
    end else if (state_next_s == ST_CLEAR) begin
      lock_l_r <= 4'd0;
      lock_r_r <= 4'd0;
    end else begin
      if (accept_l_s) begin
        lock_l_r <= 4'(LOCKOUT_CYCLES);
      end else if (lock_l_r != 4'd0) begin
        lock_l_r <= lock_l_r - 4'd1;
      end
      if (accept_r_s) begin
        lock_r_r <= 4'(LOCKOUT_CYCLES);
      end else if (lock_r_r != 4'd0) begin
        lock_r_r <= lock_r_r - 4'd1;
      end
    end
  end
`else
  assign accept_l_s = fwd_l_s;
  assign accept_r_s = fwd_r_s;
`endif

  // Registered press pulses to the playfield.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressL <= 1'b0;
      pressR <= 1'b0;
    end else begin
      pressL <= accept_l_s;
      pressR <= accept_r_s;
    end
  end

  assign score_hit_s = (scoreL == WIN_SCORE) || (scoreR == WIN_SCORE);

  // Match state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Match sequencing: round setup, play, result hold, match decided.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_CLEAR;
        else       state_next_s = ST_IDLE;
      end
      ST_CLEAR: begin
        state_next_s = ST_PLAY;
      end
      ST_PLAY: begin
        if (pf_winL || pf_winR) state_next_s = ST_ROUND_END;
        else                    state_next_s = ST_PLAY;
      end
      ST_ROUND_END: begin
        if (hold_cnt_r == HOLD_LAST) begin
          if (score_hit_s) state_next_s = ST_MATCH_END;
          else             state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_ROUND_END;
        end
      end
      ST_MATCH_END: begin
        if (start) state_next_s = ST_CLEAR;
        else       state_next_s = ST_MATCH_END;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Result hold counter; idles at zero so it is ready on entry to ROUND_END.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_r <= 8'd0;
    end else if (state_r == ST_ROUND_END) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= 8'd0;
    end
  end

  // Scores and winner; a tied round (both flags) leaves scores untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scoreL       <= 3'd0;
      scoreR       <= 3'd0;
      match_winner <= 2'b00;
    end else begin
      if (state_r == ST_PLAY && pf_winL && !pf_winR && scoreL != WIN_SCORE) begin
        scoreL <= scoreL + 3'd1;
      end
      if (state_r == ST_PLAY && pf_winR && !pf_winL && scoreR != WIN_SCORE) begin
        scoreR <= scoreR + 3'd1;
      end
      if (state_r == ST_ROUND_END && state_next_s == ST_MATCH_END) begin
        match_winner <= (scoreL == WIN_SCORE) ? 2'b01 : 2'b10;
      end
      if (state_r == ST_MATCH_END && start) begin
        scoreL       <= 3'd0;
        scoreR       <= 3'd0;
        match_winner <= 2'b00;
      end
    end
  end

  assign pf_reset   = (state_r == ST_IDLE) || (state_r == ST_CLEAR);
  assign match_over = (state_r == ST_MATCH_END);

endmodule

// File: tb/tb_tow_match_ctrl.sv
// tb_tow_match_ctrl: self-checking bench for tow_match_ctrl.
//   Directed scenarios followed by randomized play, every cycle compared with
//   a behavioural model built from the game rules.
module tb_tow_match_ctrl;

  localparam int WIN  = 2;
  localparam int HOLD = 4;
`ifdef TOW_LOCKOUT_EN
  localparam int LOCK = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       keyL, keyR, start, pf_winL, pf_winR;
  logic       pressL, pressR, pf_reset, match_over;
  logic [2:0] scoreL, scoreR;
  logic [1:0] match_winner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tow_match_ctrl #(
    .WIN_ROUNDS    (WIN),
    .HOLD_CYCLES   (HOLD),
    .LOCKOUT_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keyL        (keyL),
    .keyR        (keyR),
    .start       (start),
    .pf_winL     (pf_winL),
    .pf_winR     (pf_winR),
    .pressL      (pressL),
    .pressR      (pressR),
    .pf_reset    (pf_reset),
    .scoreL      (scoreL),
    .scoreR      (scoreR),
    .match_over  (match_over),
    .match_winner(match_winner)
  );

  // Reference model: game phase, scores, winner and button sample history.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_ROUND = 3, M_MATCH = 4;
  int m_mode, m_sl, m_sr, m_win, m_hold;
`ifdef TOW_LOCKOUT_EN
  int m_lockl, m_lockr;
`endif
  bit m_pl, m_pr;
  bit hq_l[$];
  bit hq_r[$];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_win = 0; m_hold = 0;
    m_pl = 1'b0; m_pr = 1'b0;
`ifdef TOW_LOCKOUT_EN
    m_lockl = 0; m_lockr = 0;
`endif
    hq_l.delete();
    hq_r.delete();
  endfunction

  // One rising edge. A press appears on the edge that samples the key high for
  // the third time, provided the sample before that run was a real low sample.
  function automatic void m_edge(bit kl, bit kr, bit st, bit wl, bit wr);
    bit cl, cr, fl, fr;
    int nxt;
    cl = (hq_l.size() >= 3) && hq_l[$-1] && !hq_l[$-2];
    cr = (hq_r.size() >= 3) && hq_r[$-1] && !hq_r[$-2];
    hq_l.push_back(kl);
    hq_r.push_back(kr);
    if (hq_l.size() > 4) void'(hq_l.pop_front());
    if (hq_r.size() > 4) void'(hq_r.pop_front());
    fl = (m_mode == M_PLAY) && cl && !cr;
    fr = (m_mode == M_PLAY) && cr && !cl;
`ifdef TOW_LOCKOUT_EN
    fl = fl && (m_lockl == 0);
    fr = fr && (m_lockr == 0);
`endif
    m_pl = fl;
    m_pr = fr;
    nxt = m_mode;
    case (m_mode)
      M_IDLE:  if (st) nxt = M_CLEAR;
      M_CLEAR: nxt = M_PLAY;
      M_PLAY: begin
        if (wl || wr) begin
          if (wl && !wr && m_sl < WIN) m_sl++;
          if (wr && !wl && m_sr < WIN) m_sr++;
          m_hold = HOLD;
          nxt = M_ROUND;
        end
      end
      M_ROUND: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_sl == WIN || m_sr == WIN) begin
            nxt = M_MATCH;
            m_win = (m_sl == WIN) ? 1 : 2;
          end else begin
            nxt = M_CLEAR;
          end
        end
      end
      M_MATCH: begin
        if (st) begin
          nxt = M_CLEAR; m_sl = 0; m_sr = 0; m_win = 0;
        end
      end
      default: nxt = M_IDLE;
    endcase
`ifdef TOW_LOCKOUT_EN
    if (nxt == M_CLEAR) begin
      m_lockl = 0; m_lockr = 0;
    end else begin
      if (fl) m_lockl = LOCK; else if (m_lockl > 0) m_lockl--;
      if (fr) m_lockr = LOCK; else if (m_lockr > 0) m_lockr--;
    end
`endif
    m_mode = nxt;
  endfunction

  task automatic check_all();
    chk("pressL", 8'(pressL), 8'(m_pl));
    chk("pressR", 8'(pressR), 8'(m_pr));
    chk("pf_reset", 8'(pf_reset), 8'((m_mode == M_IDLE) || (m_mode == M_CLEAR)));
    chk("match_over", 8'(match_over), 8'(m_mode == M_MATCH));
    chk("match_winner", 8'(match_winner), 8'(m_win));
    chk("scoreL", 8'(scoreL), 8'(m_sl));
    chk("scoreR", 8'(scoreR), 8'(m_sr));
  endtask

  // Drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
  task automatic cyc(input bit kl, input bit kr, input bit st, input bit wl, input bit wr);
    keyL = kl; keyR = kr; start = st; pf_winL = wl; pf_winR = wr;
    @(posedge clk);
    m_edge(kl, kr, st, wl, wr);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset in the middle of a low clock phase; keys keep their current level.
  task automatic do_reset();
    start = 1'b0; pf_winL = 1'b0; pf_winR = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_pf_reset", 8'(pf_reset), 8'd1);
    chk("async_scoreL", 8'(scoreL), 8'd0);
    chk("async_scoreR", 8'(scoreR), 8'd0);
    chk("async_pressL", 8'(pressL), 8'd0);
    chk("async_match_over", 8'(match_over), 8'd0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_all();
  endtask

  int pc, pc_r, first_i, exp_close;
  bit rkl, rkr;

  initial begin
    reset = 1'b0; keyL = 1'b0; keyR = 1'b0; start = 1'b0; pf_winL = 1'b0; pf_winR = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Single long press: exactly one pulse, third sampling edge; pf_reset in CLEAR.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("clear_pf_reset", 8'(pf_reset), 8'd1);
    pc = 0; first_i = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 0) chk("play_pf_reset", 8'(pf_reset), 8'd0);
      if (pressL) begin
        pc++;
        if (first_i < 0) first_i = i;
      end
    end
    chk("long_press_count", 8'(pc), 8'd1);
    chk("long_press_latency", 8'(first_i), 8'd2);
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Both keys rising together cancel.
    pc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (pressL || pressR) pc++;
    end
    chk("tie_press_count", 8'(pc), 8'd0);
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Presses one idle cycle apart, then two idle cycles apart.
`ifdef TOW_LOCKOUT_EN
    exp_close = 1;
`else
    exp_close = 2;
`endif
    pc = 0;
    cyc(1, 0, 0, 0, 0); if (pressL) pc++;
    cyc(0, 0, 0, 0, 0); if (pressL) pc++;
    cyc(1, 0, 0, 0, 0); if (pressL) pc++;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (pressL) pc++;
    end
    chk("close_presses", 8'(pc), 8'(exp_close));
    pc_r = 0;
    cyc(0, 1, 0, 0, 0); if (pressR) pc_r++;
    cyc(0, 0, 0, 0, 0); if (pressR) pc_r++;
    cyc(0, 0, 0, 0, 0); if (pressR) pc_r++;
    cyc(0, 1, 0, 0, 0); if (pressR) pc_r++;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (pressR) pc_r++;
    end
    chk("spaced_presses", 8'(pc_r), 8'd2);

    // Both win flags together: no score change, hold, then a new round.
    cyc(0, 0, 0, 1, 1);
    chk("tie_round_scoreL", 8'(scoreL), 8'd0);
    chk("tie_round_scoreR", 8'(scoreR), 8'd0);
    repeat (HOLD) cyc(0, 0, 0, 0, 0);
    chk("tie_round_clear", 8'(pf_reset), 8'd1);
    cyc(0, 0, 0, 0, 0);

    // Right player takes two rounds and the match.
    cyc(0, 0, 0, 0, 1);
    chk("r1_scoreR", 8'(scoreR), 8'd1);
    repeat (HOLD) cyc(0, 0, 0, 0, 0);
    chk("r1_clear", 8'(pf_reset), 8'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("r2_scoreR", 8'(scoreR), 8'd2);
    repeat (HOLD - 1) cyc(0, 0, 0, 0, 0);
    chk("hold_not_done", 8'(match_over), 8'd0);
    cyc(0, 0, 0, 0, 0);
    chk("match_over", 8'(match_over), 8'd1);
    chk("match_winner_right", 8'(match_winner), 8'd2);
    cyc(0, 0, 1, 0, 0);
    chk("restart_scoreR", 8'(scoreR), 8'd0);
    chk("restart_winner", 8'(match_winner), 8'd0);
    cyc(0, 0, 0, 0, 0);

    // Reset in the middle of a result hold.
    cyc(0, 0, 0, 1, 0);
    chk("pre_reset_scoreL", 8'(scoreL), 8'd1);
    cyc(0, 0, 0, 0, 0);
    do_reset();

    // Key held through reset release must not press.
    keyL = 1'b1;
    do_reset();
    pc = 0;
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (pressL) pc++;
    end
    chk("held_through_reset", 8'(pc), 8'd0);

    // Randomized play against the model.
    rkl = 1'b0; rkr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) rkl = ~rkl;
      if ($urandom_range(2) == 0) rkr = ~rkr;
      if ($urandom_range(499) == 0) begin
        keyL = rkl; keyR = rkr;
        do_reset();
      end else begin
        cyc(rkl, rkr, $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
